// File: rtl/s2_dist.sv
// s2_dist: routes one input word per cycle to one of four registered output
// channels chosen by the A1/B1/A0/B0 select lines.  Each channel is a
// single-entry skid-free register with valid/ready handshake; a draining
// channel can be refilled in the same cycle without a bubble.
module s2_dist #(
  parameter int size = 5
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic [size-1:0] din,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            A1,
  input  logic            B1,
  input  logic            A0,
  input  logic            B0,
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic [size-1:0] out2,
  output logic [size-1:0] out3,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [7:0]      acc_cnt
);

  logic [1:0]      sel_s;
  logic [3:0]      drain_s;
  logic            in_ready_s;
  logic            accept_s;

  logic [size-1:0] data_q [4];
  logic [size-1:0] data_d [4];
  logic [3:0]      valid_q;
  logic [3:0]      valid_d;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;

  // Decode the target channel, the per-channel drain condition and the
  // combinational accept handshake (independent of in_valid by design).
  always_comb begin
    sel_s      = {A1 & B1, A0 | B0};
    drain_s    = valid_q & out_ready;
    in_ready_s = ~valid_q[sel_s] | drain_s[sel_s];
    accept_s   = in_valid & in_ready_s;
  end

  // Next-state: drains clear valid, an accept loads the target and counts.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~drain_s;
    cnt_d   = cnt_q;
    if (accept_s) begin
      data_d[sel_s]  = din;
      valid_d[sel_s] = 1'b1;
      cnt_d          = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low clear taking priority.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      data_q  <= '{default: '0};
      valid_q <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out_valid = valid_q;
  assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_s2_dist.sv
// Self-checking bench for s2_dist: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model and a
// per-channel word scoreboard.
module tb_s2_dist;

  localparam int W = 5;

  logic         clk;
  logic         CLR;
  logic [W-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic         A1, B1, A0, B0;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [7:0]   acc_cnt;

  s2_dist #(.size(W)) dut (
    .clk(clk), .CLR(CLR), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready), .acc_cnt(acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_data [4];
  logic [3:0]   m_valid;
  int           m_cnt;
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] dout [4];

  assign dout[0] = out0;
  assign dout[1] = out1;
  assign dout[2] = out2;
  assign dout[3] = out3;

  initial begin
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    m_valid = 4'b0000;
    m_cnt   = 0;
  end

  // Compare process: mid-cycle check of every output, then advance the model
  // to the state the next rising edge must produce.
  always @(negedge clk) begin
    int sel;
    bit exp_rdy;
    bit acc;
    logic [W-1:0] w;
    sel     = ((A1 && B1) ? 2 : 0) + ((A0 || B0) ? 1 : 0);
    exp_rdy = !m_valid[sel] || out_ready[sel];
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("acc_cnt", acc_cnt, m_cnt);
    for (int i = 0; i < 4; i++) chk("out_data", dout[i], m_data[i]);

    if (!CLR) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i] = '0;
        exp_q[i].delete();
      end
      m_valid = 4'b0000;
      m_cnt   = 0;
    end else begin
      // scoreboard: each delivered word must be the oldest one routed there
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("sb_spurious", 32'd1, 32'd0);
          end else begin
            w = exp_q[i].pop_front();
            chk("sb_order", dout[i], w);
          end
        end
        if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        m_data[sel]  = din;
        m_valid[sel] = 1'b1;
        m_cnt        = (m_cnt + 1) % 256;
        exp_q[sel].push_back(din);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] combo [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic iv, input logic [3:0] c, input logic [W-1:0] d,
                       input logic [3:0] ordy);
    in_valid  = iv;
    {A1, B1, A0, B0} = c;
    din       = d;
    out_ready = ordy;
  endtask

  initial begin
    logic last_acc;
    logic prev_clr;
    combo[0] = 4'b0000;
    combo[1] = 4'b0010;
    combo[2] = 4'b1100;
    combo[3] = 4'b1101;
    CLR = 1'b0;
    offer(1'b0, 4'b0000, 5'h00, 4'b0000);
    step();
    step();
    CLR = 1'b1;

    // reset state and in_ready for every select combination
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_cnt", acc_cnt, 8'd0);
    for (int c = 0; c < 16; c++) begin
      offer(1'b0, c[3:0], 5'h00, 4'b0000);
      #1;
      chk("rst_ready", in_ready, 1'b1);
    end
    step();

    // basic routing to sel=2
    offer(1'b1, 4'b1100, 5'h11, 4'b0000);
    step();
    offer(1'b0, 4'b1100, 5'h11, 4'b0000);
    #1;
    chk("route_out2", out2, 5'h11);
    chk("route_valid", out_valid, 4'b0100);
    chk("route_cnt", acc_cnt, 8'd1);

    // mid-cycle CLR glitch away from edges has no effect
    CLR = 1'b0;
    #1;
    CLR = 1'b1;
    step();
    chk("glitch_out2", out2, 5'h11);
    chk("glitch_cnt", acc_cnt, 8'd1);

    // backpressure then zero-bubble refill
    offer(1'b1, 4'b1100, 5'h07, 4'b0000);
    #1;
    chk("bp_ready0", in_ready, 1'b0);
    step();
    chk("bp_held_out2", out2, 5'h11);
    out_ready = 4'b0100;
    #1;
    chk("bp_ready1", in_ready, 1'b1);
    step();
    offer(1'b0, 4'b0000, 5'h00, 4'b0000);
    #1;
    chk("bp_out2", out2, 5'h07);
    chk("bp_valid2", out_valid[2], 1'b1);
    chk("bp_cnt", acc_cnt, 8'd2);

    // full decode with all consumers ready
    for (int j = 0; j < 4; j++) begin
      offer(1'b1, combo[j], 5'(j + 1), 4'hF);
      step();
      chk("dec_data", dout[j], 5'(j + 1));
      chk("dec_valid", out_valid, 4'b0001 << j);
    end
    offer(1'b0, 4'b0000, 5'h00, 4'hF);
    step();
    chk("dec_empty", out_valid, 4'b0000);
    chk("dec_cnt", acc_cnt, 8'd6);

    // wrap: 256 accepts into channel 0 starting from a fresh reset
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    for (int i = 0; i < 256; i++) begin
      offer(1'b1, 4'b0000, 5'(i), 4'b0001);
      step();
      if (i == 254) chk("wrap_255", acc_cnt, 8'd255);
    end
    offer(1'b0, 4'b0000, 5'h00, 4'b0000);
    #1;
    chk("wrap_cnt", acc_cnt, 8'd0);
    chk("wrap_out0", out0, 5'h1f);

    // reset mid-operation with all channels full
    offer(1'b0, 4'b0000, 5'h00, 4'hF);
    step();
    for (int j = 0; j < 4; j++) begin
      offer(1'b1, combo[j], 5'(j + 9), 4'b0000);
      step();
    end
    offer(1'b0, 4'b0000, 5'h00, 4'b0000);
    #1;
    chk("full_valid", out_valid, 4'hF);
    CLR = 1'b0;
    offer(1'b1, combo[1], 5'h1f, 4'b0000);
    step();
    CLR = 1'b1;
    offer(1'b0, 4'b0000, 5'h00, 4'b0000);
    #1;
    chk("mrst_valid", out_valid, 4'b0000);
    chk("mrst_cnt", acc_cnt, 8'd0);
    chk("mrst_out1", out1, 5'h00);
    chk("mrst_out3", out3, 5'h00);
    step();
    chk("mrst_absent", out_valid, 4'b0000);

    // random stress; the source holds an unaccepted offer
    last_acc = 1'b1;
    prev_clr = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (!(in_valid && !last_acc && prev_clr)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        {A1, B1, A0, B0} = 4'($urandom_range(0, 15));
        din = W'($urandom);
      end
      out_ready = 4'($urandom_range(0, 15));
      CLR = ($urandom_range(0, 99) != 0);
      #2;
      last_acc = in_valid & in_ready;
      prev_clr = CLR;
      step();
    end
    CLR = 1'b1;
    offer(1'b0, 4'b0000, 5'h00, 4'hF);
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) chk("sb_leftover", exp_q[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/s2_dist.md
S2_DIST -- requirements
Module: s2_dist

Interface
REQ-001 Parameter: size, default 5, data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset; synchronous, active-low (CLR=0 at a rising clk edge resets).
REQ-004 din  input  size  data word to distribute.
REQ-005 in_valid  input  1  din and select lines hold a valid word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 A1, B1, A0, B0  input  1 each  channel select lines, decoded per REQ-012.
REQ-008 out0, out1, out2, out3  output  size each  registered channel data.
REQ-009 out_valid  output  4  bit i: outi holds an undelivered word.
REQ-010 out_ready  input  4  bit i: channel i consumer takes outi this cycle.
REQ-011 acc_cnt  output  8  count of accepted words, modulo 256.

Function
REQ-012 Channel index sel = {A1&B1, A0|B0}; sel=0..3 targets out0..out3.
REQ-013 Channel i "drains" in a cycle when out_valid[i]=1 and out_ready[i]=1.
REQ-014 in_ready is combinational: 1 when out_valid[sel]=0 or channel sel drains this cycle; otherwise 0.
REQ-015 in_ready depends only on the select lines, out_valid and out_ready, never on in_valid.
REQ-016 Accept = in_valid & in_ready; on accept, out<sel> <= din and out_valid[sel] <= 1 at the next edge.
REQ-017 Zero-bubble refill: accept into a draining channel loads the new word, and out_valid stays 1.
REQ-018 A draining channel not refilled clears out_valid[i] at the next edge; its outi data is held unchanged.
REQ-019 Non-target channels drain independently in the same cycle as an accept.
REQ-020 outi changes only on an accept into channel i or on reset.
REQ-021 While out_valid[i]=1 and channel i is not draining, outi is stable and offers to sel=i see in_ready=0.
REQ-022 An offer with in_ready=0 is not consumed; the source holds din and the select lines until accepted.
REQ-023 acc_cnt increments by 1 per accept and wraps 255 -> 0.
REQ-024 Latency: a word accepted at edge k is visible on out<sel> with out_valid set after edge k, one cycle.
REQ-025 out_ready on a channel with out_valid=0 has no effect.
REQ-026 The select lines and din are ignored whenever in_valid=0.

Reset
REQ-027 With CLR=0 at a rising edge: out0..out3 = 0, out_valid = 4'b0000, acc_cnt = 0.
REQ-028 Reset has priority over simultaneous accept or drain; a word offered in the reset cycle is discarded and not counted.
REQ-029 After release, in_ready = 1 for every sel until a channel fills.
REQ-030 CLR is sampled only at clock edges; mid-cycle CLR glitches have no effect.

Verification
REQ-031 Basic routing. Reset, then offer din=5'h11 with A1=1, B1=1, A0=0, B0=0 (sel=2) and in_valid=1, out_ready=0. Required: out2=5'h11, out_valid=4'b0100, acc_cnt=1.
REQ-032 Backpressure. With channel 2 full, out_ready=0, and din=5'h07 offered at sel=2: in_ready=0. Then raise out_ready[2]. Required: in_ready=1 in that cycle, and next cycle out2=5'h07, out_valid[2]=1.
REQ-033 Full decode. Over four cycles, offer sel values 0..3 using select combos (0,0,0,0), (0,0,1,0), (1,1,0,0), (1,1,0,1) with data 1,2,3,4 and out_ready=4'hF. Required: each outi receives data i+1, and out_valid pulses once per channel.
REQ-034 Wrap. Run 256 accepts to channel 0 with out_ready[0]=1. Required: acc_cnt returns to 0 and the last out0 equals the last din.
REQ-035 Reset mid-operation. With all channels full, drive CLR=0 for one edge while in_valid=1. Required: all outputs 0, out_valid=0, acc_cnt=0, and the offered word is absent afterwards.
REQ-036 Random stress. Random in_valid, select lines and out_ready against a scoreboard. Required: no word lost, duplicated or misrouted, and per-channel order preserved.
